// File: rtl/mux_oht_pipe.sv
// Pipelined one-hot select multiplexer built as a radix-SPLIT AND-OR tree.
// A register stage follows every REG_EVERY tree levels; the last level is
// always registered and drives the m_* outputs. Each node also produces a
// hit flag (any select below it) and an err flag (two or more selects below it).
//
// Handshake: a transfer happens on a rising edge where vld && rdy. Each stage
// keeps one valid bit; stage k may load when it is empty or when everything
// downstream of it can advance: rdy_k = ~vld_k | rdy_(k+1), with the last
// stage using m_rdy. s_rdy is rdy_0. A stage that is not ready holds its data,
// flags and valid bit, so outputs stay stable while m_vld=1 and m_rdy=0.
module mux_oht_pipe #(
    parameter type DAT_T     = logic [8-1:0],
    parameter int  WIDTH     = 32,
    parameter int  SPLIT     = 2,
    parameter int  REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [WIDTH-1:0] s_oht,
    input  DAT_T             s_ary [WIDTH],
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_hit,
    output logic             m_err,
    output DAT_T             m_dat
);

    function automatic int calc_levels(input int w, input int s);
        int l;
        int p;
        l = 0;
        p = 1;
        while (p < w) begin
            p = p * s;
            l = l + 1;
        end
        return l;
    endfunction

    function automatic int ipow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    localparam int LEVELS  = calc_levels(WIDTH, SPLIT);
    localparam int POWER   = ipow(SPLIT, LEVELS);
    localparam int LATENCY = (LEVELS + REG_EVERY - 1) / REG_EVERY;

    // Per-level combinational node outputs and per-stage registered outputs.
    // Only the low entries of each row carry real nodes; the rest are tied to 0.
    DAT_T             lv_dat [LEVELS][POWER];
    logic [POWER-1:0] lv_hit [LEVELS];
    logic [POWER-1:0] lv_err [LEVELS];
    DAT_T             st_dat [LATENCY][POWER];
    logic [POWER-1:0] st_hit [LATENCY];
    logic [POWER-1:0] st_err [LATENCY];

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] rdy;
    logic [LATENCY-1:0] vin;

    // Unrolled ready chain: a stage can load if any stage from it to the
    // output is empty, or the consumer accepts.
    for (genvar k = 0; k < LATENCY; k++) begin : g_rdy
        assign rdy[k] = m_rdy | ~(&vld[LATENCY-1:k]);
    end

    if (LATENCY == 1) begin : g_vin_one
        assign vin = s_vld;
    end else begin : g_vin_many
        assign vin = {vld[LATENCY-2:0], s_vld};
    end

    // Stage valid bits advance only where the stage is ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (rdy[k]) vld[k] <= vin[k];
            end
        end
    end

    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        localparam int NCNT   = POWER / ipow(SPLIT, j + 1);
        localparam bit IS_REG = (((j + 1) % REG_EVERY) == 0) || (j == LEVELS - 1);
        localparam int STG    = j / REG_EVERY;

        DAT_T             in_dat [POWER];
        logic [POWER-1:0] in_hit;
        logic [POWER-1:0] in_err;
        DAT_T             nd_dat [POWER];
        logic [POWER-1:0] nd_hit;
        logic [POWER-1:0] nd_err;

        if (j == 0) begin : g_leaf
            // Leaves beyond WIDTH are constant zero so the tree prunes them.
            for (genvar n = 0; n < POWER; n++) begin : g_pad
                if (n < WIDTH) begin : g_real
                    assign in_dat[n] = s_ary[n];
                    assign in_hit[n] = s_oht[n];
                end else begin : g_zero
                    assign in_dat[n] = '0;
                    assign in_hit[n] = 1'b0;
                end
            end
            assign in_err = '0;
        end else if ((j % REG_EVERY) == 0) begin : g_src_reg
            assign in_dat = st_dat[j / REG_EVERY - 1];
            assign in_hit = st_hit[j / REG_EVERY - 1];
            assign in_err = st_err[j / REG_EVERY - 1];
        end else begin : g_src_comb
            assign in_dat = lv_dat[j - 1];
            assign in_hit = lv_hit[j - 1];
            assign in_err = lv_err[j - 1];
        end

        // AND-OR reduction of SPLIT children; a second child hit flags err.
        always_comb begin
            for (int n = 0; n < POWER; n++) begin
                nd_dat[n] = '0;
                nd_hit[n] = 1'b0;
                nd_err[n] = 1'b0;
            end
            for (int n = 0; n < NCNT; n++) begin
                for (int c = 0; c < SPLIT; c++) begin
                    if (in_hit[n*SPLIT+c]) begin
                        nd_err[n] = nd_err[n] | nd_hit[n];
                        nd_dat[n] = nd_dat[n] | in_dat[n*SPLIT+c];
                        nd_hit[n] = 1'b1;
                    end
                    nd_err[n] = nd_err[n] | in_err[n*SPLIT+c];
                end
            end
        end

        assign lv_dat[j] = nd_dat;
        assign lv_hit[j] = nd_hit;
        assign lv_err[j] = nd_err;

        if (IS_REG) begin : g_reg
            DAT_T             q_dat [POWER];
            logic [POWER-1:0] q_hit;
            logic [POWER-1:0] q_err;

            // Pipeline register for this level; holds while the stage is stalled.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int n = 0; n < POWER; n++) q_dat[n] <= '0;
                    q_hit <= '0;
                    q_err <= '0;
                end else if (rdy[STG]) begin
                    q_dat <= nd_dat;
                    q_hit <= nd_hit;
                    q_err <= nd_err;
                end
            end

            assign st_dat[STG] = q_dat;
            assign st_hit[STG] = q_hit;
            assign st_err[STG] = q_err;
        end
    end

    assign s_rdy = rdy[0];
    assign m_vld = vld[LATENCY-1];
    assign m_dat = st_dat[LATENCY-1][0];
    assign m_hit = st_hit[LATENCY-1][0];
    assign m_err = st_err[LATENCY-1][0];

endmodule

// File: tb/tb_mux_oht_pipe.sv
// Bench for mux_oht_pipe: default 32-wide instance plus a padded 5-wide one.
`timescale 1ns/1ps
module tb_mux_oht_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_vld, s_rdy, m_vld, m_rdy, m_hit, m_err;
    logic [31:0] s_oht;
    logic [7:0]  s_ary [32];
    logic [7:0]  m_dat;

    logic        p_s_vld, p_s_rdy, p_m_vld, p_m_rdy, p_m_hit, p_m_err;
    logic [4:0]  p_s_oht;
    logic [7:0]  p_ary [5];
    logic [7:0]  p_m_dat;

    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  exp_q [$];
    logic        last_in_fire, last_s_rdy, prev_stall;
    logic [9:0]  prev_out, last_out;
    int          n_pop;

    always #5 clk = ~clk;

    mux_oht_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .s_vld(s_vld), .s_rdy(s_rdy), .s_oht(s_oht), .s_ary(s_ary),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_hit(m_hit), .m_err(m_err), .m_dat(m_dat)
    );

    mux_oht_pipe #(.WIDTH(5), .SPLIT(4), .REG_EVERY(1)) dut_pad (
        .clk(clk), .rst_n(rst_n),
        .s_vld(p_s_vld), .s_rdy(p_s_rdy), .s_oht(p_s_oht), .s_ary(p_ary),
        .m_vld(p_m_vld), .m_rdy(p_m_rdy), .m_hit(p_m_hit), .m_err(p_m_err), .m_dat(p_m_dat)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: OR of selected elements, hit = any select, err = more than one.
    function automatic logic [9:0] model(input logic [31:0] oht, input logic [7:0] ary [32]);
        logic [7:0] d;
        int         c;
        d = 8'h00;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if (oht[i]) begin
                d = d | ary[i];
                c++;
            end
        end
        return {(c > 1), (c > 0), d};
    endfunction

    // One clock: called at a negedge with inputs already set.
    task automatic cycle();
        logic in_fire, out_fire;
        #1;
        if (prev_stall) chk("hold", {m_vld, m_err, m_hit, m_dat}, {1'b1, prev_out});
        in_fire  = s_vld && s_rdy;
        out_fire = m_vld && m_rdy;
        last_s_rdy = s_rdy;
        if (out_fire) begin
            n_pop++;
            last_out = {m_err, m_hit, m_dat};
            if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else chk("out", {m_err, m_hit, m_dat}, exp_q.pop_front());
        end
        if (in_fire) exp_q.push_back(model(s_oht, s_ary));
        last_in_fire = in_fire;
        prev_stall = m_vld && !m_rdy;
        prev_out = {m_err, m_hit, m_dat};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int b;
        b = 0;
        s_vld = 1'b0;
        m_rdy = 1'b1;
        while (exp_q.size() != 0 && b < 50) begin
            cycle();
            b++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic base_ary();
        for (int i = 0; i < 32; i++) s_ary[i] = 8'h40 + i[7:0];
    endtask

    function automatic logic [31:0] rand_oht();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h0;
        if (r == 1) return (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        if (r == 2) return $urandom;
        return 32'h1 << $urandom_range(0, 31);
    endfunction

    initial begin
        int lat, sent, b;
        bit seen;
        rst_n = 1'b0; s_vld = 1'b1; m_rdy = 1'b1; s_oht = 32'h1;
        p_s_vld = 1'b0; p_m_rdy = 1'b1; p_s_oht = '0;
        for (int i = 0; i < 5; i++) p_ary[i] = 8'h00;
        base_ary();
        prev_stall = 1'b0; n_pop = 0; last_out = '0;

        // Reset with s_vld held high
        @(negedge clk);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("rst_m_vld", m_vld, 1'b0);
        chk("rst_m_dat", m_dat, 8'h00);
        chk("rst_m_hit", m_hit, 1'b0);
        chk("rst_m_err", m_err, 1'b0);
        rst_n = 1'b1; s_vld = 1'b0;
        #1;
        chk("rst_s_rdy", s_rdy, 1'b1);
        chk("rst_p_s_rdy", p_s_rdy, 1'b1);
        @(negedge clk);

        // Single select, latency and value
        s_oht = 32'h1 << 17; s_vld = 1'b1; m_rdy = 1'b1;
        cycle();
        s_vld = 1'b0;
        lat = 1;
        while (!m_vld && lat < 20) begin cycle(); lat++; end
        chk("latency", lat, 32'd3);
        chk("single_dat", m_dat, 8'h51);
        chk("single_hit", m_hit, 1'b1);
        chk("single_err", m_err, 1'b0);
        drain();

        // Zero select
        s_oht = 32'h0; s_vld = 1'b1;
        cycle();
        drain();
        chk("zero_direct", last_out, 10'h000);

        // Multi-hot select
        s_ary[1] = 8'h0F; s_ary[2] = 8'hF0;
        s_oht = (32'h1 << 1) | (32'h1 << 2); s_vld = 1'b1;
        cycle();
        drain();
        chk("multi_direct", last_out, {1'b1, 1'b1, 8'hFF});
        base_ary();

        // Backpressure: 6 transfers, m_rdy low for cycles 2..7
        sent = 0; seen = 1'b0; n_pop = 0; b = 0;
        while ((sent < 6 || exp_q.size() != 0) && b < 40) begin
            m_rdy = !(b >= 2 && b <= 7);
            s_vld = (sent < 6);
            s_oht = 32'h1 << sent;
            cycle();
            if (last_in_fire) sent++;
            if (!last_s_rdy && !seen) begin
                seen = 1'b1;
                chk("bp_accepted_before_stall", sent, 32'd3);
            end
            b++;
        end
        chk("bp_stall_seen", seen, 1'b1);
        chk("bp_sent", sent, 32'd6);
        chk("bp_outputs", n_pop, 32'd6);
        drain();

        // Padded instance: WIDTH=5, SPLIT=4, REG_EVERY=1
        for (int i = 0; i < 5; i++) p_ary[i] = 8'h11 << i;
        p_ary[4] = 8'hA5;
        p_s_oht = 5'b10000; p_s_vld = 1'b1; p_m_rdy = 1'b1;
        #1;
        chk("pad_s_rdy", p_s_rdy, 1'b1);
        @(posedge clk); @(negedge clk);
        p_s_vld = 1'b0;
        lat = 1;
        while (!p_m_vld && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
        chk("pad_latency", lat, 32'd2);
        chk("pad_dat", p_m_dat, 8'hA5);
        chk("pad_hit", p_m_hit, 1'b1);
        chk("pad_err", p_m_err, 1'b0);
        p_s_oht = 5'b00011; p_s_vld = 1'b1;
        @(posedge clk); @(negedge clk);
        p_s_vld = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pad_multi", {p_m_vld, p_m_err, p_m_hit, p_m_dat}, {1'b1, 1'b1, 1'b1, p_ary[0] | p_ary[1]});
        @(posedge clk); @(negedge clk);

        // Reset mid-stream with three transfers in flight
        m_rdy = 1'b0; s_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_oht = 32'h1 << (i + 8);
            cycle();
        end
        s_vld = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        prev_stall = 1'b0;
        chk("midrst_m_vld", m_vld, 1'b0);
        m_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("no_stale", m_vld, 1'b0);
            cycle();
        end

        // Random traffic against the model
        sent = 0; b = 0;
        while (sent < 10000 && b < 60000) begin
            for (int i = 0; i < 32; i++) s_ary[i] = 8'($urandom);
            s_oht = rand_oht();
            s_vld = ($urandom_range(0, 3) != 0);
            m_rdy = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_in_fire) sent++;
            b++;
        end
        chk("rand_sent", sent, 32'd10000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
